// File: rtl/seq_div16_8_if.sv
// Handshake bundle for the sequential divider: operand side and result side,
// each with its own valid/ready pair.
interface seq_div16_8_if #(
  parameter int DW = 16,
  parameter int VW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );
endinterface

// File: rtl/seq_div16_8.sv
// Restoring divider: DW-bit dividend by VW-bit divisor, one quotient bit per clock.
// state | meaning
// IDLE  | waiting for an operand handshake
// BUSY  | DW shift/subtract iterations
// DONE  | result presented until the consumer takes it
module seq_div16_8 #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  seq_div16_8_if.slave  bus
);
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW:0]   r_q, r_d;
  logic [VW-1:0] d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dz_q, dz_d;

  logic [VW:0]   trial;
  logic [VW:0]   diff;
  logic          fits;

  // The trial value is one bit wider than the divisor so the compare never overflows.
  assign trial = {r_q[VW-1:0], q_q[DW-1]};
  assign diff  = trial - {1'b0, d_q};
  assign fits  = (trial >= {1'b0, d_q});

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          q_d   = bus.dividend;
          d_d   = bus.divisor;
          r_d   = '0;
          cnt_d = CW'(DW - 1);
          dz_d  = 1'b0;
          if (bus.divisor == '0) begin
            quo_d   = '1;
            rem_d   = bus.dividend[VW-1:0];
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        r_d   = fits ? diff : trial;
        q_d   = {q_q[DW-2:0], fits};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          quo_d   = q_d;
          rem_d   = r_d[VW-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  // Result registers are separate from the shift registers so outputs hold across the next operation.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_seq_div16_8.sv
// Directed and random bench for seq_div16_8 with a queue of expected results.
module tb_seq_div16_8;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;
  int   prev_acc;
  int   prev_lat;

  typedef struct {
    logic [15:0] quo;
    logic [7:0]  rem;
    logic        dz;
  } exp_t;

  exp_t exp_q[$];

  seq_div16_8_if #(.DW(16), .VW(8)) bus ();

  seq_div16_8 #(.DW(16), .VW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Issue one operation, hold the result for `hold` cycles, then take it.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input int hold, input bit b2b);
    exp_t e;
    int   lat;
    int   acc;
    logic [15:0] hq;
    logic [7:0]  hr;
    if (b == 0) begin
      e.quo = 16'hFFFF; e.rem = a[7:0]; e.dz = 1'b1;
    end else begin
      e.quo = a / b; e.rem = 8'(a % b); e.dz = 1'b0;
    end
    exp_q.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.dividend = a; bus.divisor = b; bus.out_ready = 1'b0;
    chk("in_ready_before_accept", bus.in_ready, 1);
    @(posedge clk);
    acc = cyc;
    #1 bus.in_valid = 1'b0;
    bus.dividend = ~a; bus.divisor = ~b;
    if (b2b) chk("issue_interval", acc - prev_acc, prev_lat + 1);
    lat = 1;
    if (b != 0) chk("in_ready_busy", bus.in_ready, 0);
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, (b == 0) ? 1 : 17);
    e = exp_q.pop_front();
    chk("quotient", bus.quotient, e.quo);
    chk("remainder", bus.remainder, e.rem);
    chk("div_zero", bus.div_zero, e.dz);
    if (!e.dz) begin
      chk("invariant_prod", bus.quotient * b + bus.remainder, a);
      chk("invariant_rem_lt", bus.remainder < b, 1);
    end
    hq = bus.quotient; hr = bus.remainder;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = i[0];
      @(posedge clk); #1;
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_quotient", bus.quotient, hq);
      chk("hold_remainder", bus.remainder, hr);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("post_out_valid", bus.out_valid, 0);
    chk("post_in_ready", bus.in_ready, 1);
    chk("retain_quotient", bus.quotient, hq);
    prev_acc = acc;
    prev_lat = lat;
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    int lat;
    total = 0; bad = 0; prev_acc = 0; prev_lat = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.dividend = '0; bus.divisor = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_quotient", bus.quotient, 0);
    chk("rst_remainder", bus.remainder, 0);
    chk("rst_div_zero", bus.div_zero, 0);

    run_op(16'd200, 8'd7, 0, 0);
    run_op(16'hFFFF, 8'hFF, 0, 0);
    run_op(16'hFFFF, 8'd1, 0, 0);
    run_op(16'd5, 8'd9, 0, 0);
    run_op(16'h1234, 8'd0, 0, 0);
    run_op(16'd1000, 8'd13, 10, 0);
    run_op(16'd0, 8'd200, 0, 0);

    // Reset in the middle of an operation discards it.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.dividend = 16'd500; bus.divisor = 8'd3;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_quotient", bus.quotient, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    repeat (20) @(posedge clk);
    #1 chk("midrst_no_output", bus.out_valid, 0);
    run_op(16'd500, 8'd3, 0, 0);

    // Reset and in_valid together: nothing is accepted.
    @(negedge clk);
    rst = 1'b1; bus.in_valid = 1'b1; bus.dividend = 16'd9; bus.divisor = 8'd0;
    @(posedge clk); #1 rst = 1'b0; bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("rst_vs_valid_out_valid", bus.out_valid, 0);
    chk("rst_vs_valid_in_ready", bus.in_ready, 1);

    // Reset beats out_ready in DONE.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.dividend = 16'h00AB; bus.divisor = 8'd0;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    chk("dz_done_valid", bus.out_valid, 1);
    rst = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0; bus.out_ready = 1'b0;
    chk("rst_done_out_valid", bus.out_valid, 0);
    chk("rst_done_div_zero", bus.div_zero, 0);
    chk("rst_done_remainder", bus.remainder, 0);

    // Random back-to-back stream at the minimum interval.
    run_op(16'd77, 8'd5, 0, 0);
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 9))
        0:       rb = 8'd0;
        1:       rb = 8'd1;
        default: rb = 8'($urandom);
      endcase
      run_op(ra, rb, 0, 1);
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
